// File: rtl/a2d_pkg.sv
// Shared types, constants and the noise helper for the A2D SPI responder model.
package a2d_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, TAIL, DRAIN} serf_state_t;

    localparam int FRAME_BITS = 16;
    localparam int CH_LSB     = 11;
    localparam int CH_W       = 3;
    localparam int DATA_W     = 12;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Adds a signed nibble clamped to [-7,+7] and saturates to the 12-bit range.
    function automatic logic [DATA_W-1:0] add_noise(input logic [DATA_W-1:0] value,
                                                      input logic [3:0] nib);
        logic [4:0]  delta;
        logic [13:0] sum;
        delta = (nib == 4'h8) ? 5'h19 : {nib[3], nib};
        sum   = {2'b00, value} + {{9{delta[4]}}, delta};
        if (sum[13])
            return '0;
        else if (sum[12])
            return '1;
        else
            return sum[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/a2d_sync_edge.sv
// Three-flop synchronizer with rise/fall strobes; RST_VAL sets the idle level.
module a2d_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/a2d_spi_serf.sv
// SPI responder emulating the 8-channel 12-bit A2D; replies one frame late.
// Optional macro A2D_SERF_NOISE_EN adds LFSR dither to the returned value.
module a2d_spi_serf
    import a2d_pkg::*;
#(
    parameter int NUM_CH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     SS_n,
    input  logic                     SCLK,
    input  logic                     MOSI,
    output logic                     MISO,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [FRAME_BITS-1:0]    rx_data,
    output logic [CH_W-1:0]          chan,
    output logic                     done,
    output logic                     frm_err
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    serf_state_t           state;
    logic [FRAME_BITS-1:0] tx_shft;
    logic [FRAME_BITS-1:0] rx_shft;
    logic [CNT_W-1:0]      bit_cnt;

    logic ss_sync, rise_ss, fall_ss;
    logic sclk_level_unused, rise_sclk, fall_sclk;
    logic mosi_meta, mosi_sync;

    logic [DATA_W-1:0] ch_arr [NUM_CH];
    logic [IDX_W-1:0]  ch_idx;
    logic [DATA_W-1:0] ch_sel;
    logic [DATA_W-1:0] reply;

    // SS_n resets to "selected" so a frame already in progress at reset release is drained.
    a2d_sync_edge #(.RST_VAL(1'b0)) u_ss_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (SS_n),
        .sync  (ss_sync),
        .rise  (rise_ss),
        .fall  (fall_ss)
    );

    a2d_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (SCLK),
        .sync  (sclk_level_unused),
        .rise  (rise_sclk),
        .fall  (fall_sclk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_meta <= MOSI;
            mosi_sync <= mosi_meta;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_arr[k] = ch_data[k*DATA_W +: DATA_W];
    end

    assign ch_idx = IDX_W'(32'(chan) % NUM_CH);
    assign ch_sel = ch_arr[ch_idx];

`ifdef A2D_SERF_NOISE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= LFSR_SEED;
        else if (fall_ss)
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    assign reply = add_noise(ch_sel, lfsr[3:0]);
`else
    assign reply = ch_sel;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx_shft <= '0;
            rx_shft <= '0;
            bit_cnt <= '0;
            rx_data <= '0;
            chan    <= '0;
            done    <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            done    <= 1'b0;
            frm_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall_ss) begin
                        tx_shft <= {{(FRAME_BITS-DATA_W){1'b0}}, reply};
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else if (!ss_sync) begin
                        // Selected without a visible fall: only happens straight out of reset.
                        state <= DRAIN;
                    end
                end
                SHIFT: begin
                    if (rise_ss) begin
                        frm_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        if (rise_sclk) begin
                            rx_shft <= {rx_shft[FRAME_BITS-2:0], mosi_sync};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == CNT_W'(FRAME_BITS - 1))
                                state <= TAIL;
                        end
                        if (fall_sclk && bit_cnt != '0)
                            tx_shft <= {tx_shft[FRAME_BITS-2:0], 1'b0};
                    end
                end
                TAIL: begin
                    if (rise_sclk) begin
                        frm_err <= 1'b1;
                        state   <= rise_ss ? IDLE : DRAIN;
                    end else if (rise_ss) begin
                        rx_data <= rx_shft;
                        chan    <= rx_shft[CH_LSB +: CH_W];
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                DRAIN: begin
                    if (rise_ss)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign MISO = (state != IDLE) ? tx_shft[FRAME_BITS-1] : 1'b0;

endmodule

// File: tb/tb_a2d_spi_serf.sv
// Scoreboard bench for a2d_spi_serf: directed frames push expected MISO words and done/frm_err events.
module tb_a2d_spi_serf;

    localparam int NUM_CH = 8;

`ifdef A2D_SERF_NOISE_EN
    localparam int TOL = 7;
`else
    localparam int TOL = 0;
`endif

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 SS_n  = 1'b1;
    logic                 SCLK  = 1'b1;
    logic                 MOSI  = 1'b0;
    logic                 MISO;
    logic [NUM_CH*12-1:0] ch_data = '0;
    logic [15:0]          rx_data;
    logic [2:0]           chan;
    logic                 done;
    logic                 frm_err;

    always #5 clk = ~clk;

    a2d_spi_serf #(.NUM_CH(NUM_CH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .ch_data (ch_data),
        .rx_data (rx_data),
        .chan    (chan),
        .done    (done),
        .frm_err (frm_err)
    );

    typedef struct {
        logic [15:0] val;
        int          tol;
    } miso_exp_t;

    typedef struct {
        int          kind;
        logic [15:0] rx;
        logic [2:0]  ch;
    } evt_exp_t;

    miso_exp_t   miso_q[$];
    evt_exp_t    evt_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          mon_cnt  = 0;
    logic [15:0] mon_word = '0;

    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] exp, input int tol);
        int a, e, lo, hi;
        bit ok;
        a  = int'(act[11:0]);
        e  = int'(exp[11:0]);
        lo = (e - tol < 0) ? 0 : e - tol;
        hi = (e + tol > 4095) ? 4095 : e + tol;
        ok = !$isunknown(act) && (act[15:12] == exp[15:12]) && (a >= lo) && (a <= hi);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, want %h (tol %0d)", name, act, exp, tol);
        end
    endtask

    // Issue one frame; kind 0 = no event, 1 = done, 2 = frm_err. MISO is only scored on 16-bit frames.
    task automatic applyStimulus(input logic [15:0] mosi, input int nrise,
                                 input logic [15:0] exp_miso, input int kind,
                                 input logic [15:0] exp_rx, input logic [2:0] exp_ch,
                                 input int poke_bit, input logic [11:0] poke_val);
        miso_exp_t m;
        evt_exp_t  e;
        if (nrise == 16) begin
            m.val = exp_miso;
            m.tol = TOL;
            miso_q.push_back(m);
        end
        if (kind != 0) begin
            e.kind = kind;
            e.rx   = exp_rx;
            e.ch   = exp_ch;
            evt_q.push_back(e);
        end
        @(negedge clk);
        SS_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nrise; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? mosi[4'(15 - i)] : 1'b0;
            if (i == poke_bit)
                ch_data[11:0] = poke_val;
            repeat (8) @(negedge clk);
            SCLK = 1'b1;
            repeat (8) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        SS_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("miso_idle", {15'd0, MISO}, 16'h0000, 0);
    endtask

    // MISO monitor: assemble the word the master sees and score it when SS_n rises.
    always @(negedge SS_n) begin
        mon_cnt  = 0;
        mon_word = '0;
    end

    always @(posedge SCLK) begin
        if (SS_n == 1'b0) begin
            mon_word = {mon_word[14:0], MISO};
            mon_cnt++;
        end
    end

    always @(posedge SS_n) begin
        miso_exp_t m;
        if (mon_cnt == 16) begin
            if (miso_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL miso_scoreboard: got %h, expected nothing", mon_word);
            end else begin
                m = miso_q.pop_front();
                checkOutput("miso_word", mon_word, m.val, m.tol);
            end
        end
    end

    // Event monitor: every done/frm_err cycle must match the next expected event.
    always @(negedge clk) begin
        evt_exp_t e;
        if (rst_n && (done || frm_err)) begin
            if (evt_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL evt_scoreboard: got done=%b frm_err=%b, expected no pulse",
                         done, frm_err);
            end else begin
                e = evt_q.pop_front();
                checkOutput("evt_done", {15'd0, done}, (e.kind == 1) ? 16'h1 : 16'h0, 0);
                checkOutput("evt_err", {15'd0, frm_err}, (e.kind == 2) ? 16'h1 : 16'h0, 0);
                checkOutput("evt_rx_data", rx_data, e.rx, 0);
                checkOutput("evt_chan", {13'd0, chan}, {13'd0, e.ch}, 0);
            end
        end
    end

    initial begin
        ch_data[0*12 +: 12] = 12'h123;
        ch_data[1*12 +: 12] = 12'h000;
        ch_data[2*12 +: 12] = 12'hFFF;
        ch_data[3*12 +: 12] = 12'h800;
        ch_data[4*12 +: 12] = 12'h456;
        ch_data[5*12 +: 12] = 12'h789;
        ch_data[6*12 +: 12] = 12'hABC;
        ch_data[7*12 +: 12] = 12'h000;

        repeat (3) @(negedge clk);
        checkOutput("rst_miso", {15'd0, MISO}, 16'h0000, 0);
        checkOutput("rst_rx_data", rx_data, 16'h0000, 0);
        checkOutput("rst_chan", {13'd0, chan}, 16'h0000, 0);
        checkOutput("rst_done", {15'd0, done}, 16'h0000, 0);
        checkOutput("rst_frm_err", {15'd0, frm_err}, 16'h0000, 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        $display("[TB] first frames and round-robin");
        applyStimulus(16'h2000, 16, 16'h0123, 1, 16'h2000, 3'd4, -1, 12'h0);
        applyStimulus(16'h2000, 16, 16'h0456, 1, 16'h2000, 3'd4, -1, 12'h0);
        applyStimulus(16'h0000, 16, 16'h0456, 1, 16'h0000, 3'd0, -1, 12'h0);
        applyStimulus(16'h0000, 16, 16'h0123, 1, 16'h0000, 3'd0, -1, 12'h0);
        applyStimulus(16'h2000, 16, 16'h0123, 1, 16'h2000, 3'd4, -1, 12'h0);
        applyStimulus(16'h2000, 16, 16'h0456, 1, 16'h2000, 3'd4, -1, 12'h0);
        applyStimulus(16'h2800, 16, 16'h0456, 1, 16'h2800, 3'd5, -1, 12'h0);
        applyStimulus(16'h2800, 16, 16'h0789, 1, 16'h2800, 3'd5, -1, 12'h0);
        applyStimulus(16'h3000, 16, 16'h0789, 1, 16'h3000, 3'd6, -1, 12'h0);
        applyStimulus(16'h3000, 16, 16'h0ABC, 1, 16'h3000, 3'd6, -1, 12'h0);

        $display("[TB] short frame, over-clocked frame, mid-frame channel change");
        applyStimulus(16'h0000, 7, 16'h0000, 2, 16'h3000, 3'd6, -1, 12'h0);
        applyStimulus(16'h0000, 16, 16'h0ABC, 1, 16'h0000, 3'd0, -1, 12'h0);
        applyStimulus(16'h2000, 17, 16'h0000, 2, 16'h0000, 3'd0, -1, 12'h0);
        applyStimulus(16'h2800, 16, 16'h0123, 1, 16'h2800, 3'd5, 8, 12'hFED);
        ch_data[0*12 +: 12] = 12'h123;
        applyStimulus(16'h0000, 16, 16'h0789, 1, 16'h0000, 3'd0, -1, 12'h0);
        applyStimulus(16'h1800, 16, 16'h0123, 1, 16'h1800, 3'd3, -1, 12'h0);

        $display("[TB] reset mid-frame, released with SS_n low");
        @(negedge clk);
        SS_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            SCLK = 1'b0;
            repeat (8) @(negedge clk);
            SCLK = 1'b1;
            repeat (8) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_miso", {15'd0, MISO}, 16'h0000, 0);
        checkOutput("midrst_rx_data", rx_data, 16'h0000, 0);
        checkOutput("midrst_chan", {13'd0, chan}, 16'h0000, 0);
        checkOutput("midrst_done", {15'd0, done}, 16'h0000, 0);
        checkOutput("midrst_frm_err", {15'd0, frm_err}, 16'h0000, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            SCLK = 1'b0;
            repeat (8) @(negedge clk);
            SCLK = 1'b1;
            repeat (8) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        SS_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("postrst_rx_data", rx_data, 16'h0000, 0);
        checkOutput("postrst_chan", {13'd0, chan}, 16'h0000, 0);

        $display("[TB] boundary values 000/FFF/800");
        applyStimulus(16'h0800, 16, 16'h0123, 1, 16'h0800, 3'd1, -1, 12'h0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(16'h1000, 16, 16'h0000, 1, 16'h1000, 3'd2, -1, 12'h0);
            applyStimulus(16'h1800, 16, 16'h0FFF, 1, 16'h1800, 3'd3, -1, 12'h0);
            applyStimulus(16'h0800, 16, 16'h0800, 1, 16'h0800, 3'd1, -1, 12'h0);
        end

        repeat (20) @(negedge clk);
        checkOutput("miso_q_left", 16'(miso_q.size()), 16'h0000, 0);
        checkOutput("evt_q_left", 16'(evt_q.size()), 16'h0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
